// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Types and constants shared by the instruction fetch path.
//   NOP           : canonical RISC-V no-op (addi x0,x0,0) shown when nothing is valid
//   fetch_state_e : fetch control FSM states
//   fetch_entry_t : one prefetch buffer entry {pc, instr}
package cpu_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small prefetch buffer between instruction memory and the IF/ID register.
//   Head entry is visible combinationally so the fetch stage can present it
//   in the same cycle it becomes valid.
// Parameters:
//   DEPTH       : number of entries (power of two: 2 or 4)
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   asynchronous active-low reset
//   clear_i     in   drop all entries (wins over push/pop)
//   push_i      in   write push_data_i at the tail
//   push_data_i in   entry to write
//   pop_i       in   remove the head entry (ignored when empty)
//   head_o      out  current head entry
//   count_o     out  occupancy
//   empty_o     out  occupancy == 0
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: issues single-outstanding requests to
//   instruction memory, buffers responses in a small prefetch FIFO and
//   presents them to the IF/ID register. Branch redirects (flush_i) empty the
//   buffer and discard any response still in flight.
//   Optional build macro FETCH_BYPASS_EN: a response arriving while the
//   buffer is empty, unstalled and not flushed goes straight to the outputs
//   in the same cycle instead of being buffered.
// Parameters:
//   RESET_PC      : first fetch address after reset
//   DEPTH         : prefetch buffer entries (2 or 4)
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-low reset
//   start_i       in   fetch enable (gates new requests only)
//   stall_i       in   output not consumed this cycle
//   flush_i       in   redirect to target_i
//   target_i      in   redirect address (word aligned internally)
//   imem_req_o    out  one-cycle request pulse
//   imem_addr_o   out  request address
//   imem_rvalid_i in   response strobe
//   imem_rdata_i  in   response instruction
//   valid_o       out  instr_o/pc_o carry a real instruction
//   instr_o       out  instruction (NOP when not valid)
//   pc_o          out  address of instr_o (0 when not valid)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             outstanding_q, outstanding_d;
  logic [31:0]      req_addr_q, req_addr_d;

  logic             issue;
  logic             accept;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  always_comb begin
    // A response only matters if we are waiting for one; strays after a
    // reset are ignored because outstanding_q is clear.
    accept = imem_rvalid_i && outstanding_q;

    issue = (state_q == RUN) && start_i && !outstanding_q && !flush_i &&
            (fifo_count < CNT_W'(DEPTH));

`ifdef FETCH_BYPASS_EN
    bypass = (state_q == RUN) && accept && fifo_empty && !stall_i && !flush_i;
`else
    bypass = 1'b0;
`endif

    fifo_push  = (state_q == RUN) && accept && !flush_i && !bypass;
    fifo_pop   = !fifo_empty && !stall_i && !flush_i;
    push_entry = '{pc: req_addr_q, instr: imem_rdata_i};

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      // Flush with a response still in flight: that response belongs to the
      // old path and must be swallowed when it arrives.
      RUN:     if (flush_i && outstanding_q && !imem_rvalid_i) state_d = DISCARD;
      DISCARD: if (accept) state_d = RUN;
      default: state_d = IDLE;
    endcase

    outstanding_d = outstanding_q;
    if (issue)       outstanding_d = 1'b1;
    else if (accept) outstanding_d = 1'b0;

    req_addr_d = issue ? fetch_pc_q : req_addr_q;

    fetch_pc_d = fetch_pc_q;
    if (flush_i)    fetch_pc_d = target_i & 32'hFFFF_FFFC;
    else if (issue) fetch_pc_d = fetch_pc_q + 32'd4;  // wraps at 2^32
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      req_addr_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      req_addr_q    <= req_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = fetch_pc_q;
    valid_o     = !fifo_empty || bypass;
    instr_o     = NOP;
    pc_o        = 32'h0000_0000;
    if (bypass) begin
      instr_o = imem_rdata_i;
      pc_o    = req_addr_q;
    end else if (!fifo_empty) begin
      instr_o = fifo_head.instr;
      pc_o    = fifo_head.pc;
    end
  end

endmodule
